// File: rtl/shift_unit.sv
// Two-stage pipelined shifter with a signed shift amount (positive = left, negative = right),
// logical/arithmetic/rotate modes, carry-out and zero flags, and valid/ready on both sides.
module shift_unit #(
  parameter int WIDTH   = 16,
  parameter int SHIFT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic               out_zero
);

  // One extra bit so that negating the most negative shift yields WIDTH without overflow.
  localparam int MAG_W = SHIFT_W + 1;
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [MAG_W-1:0] MAG_FULL = MAG_W'(WIDTH);

  logic               adv1;
  logic               adv2;

  logic               s1_valid_reg;
  logic               s1_left_reg;
  logic [MAG_W-1:0]   s1_mag_reg;
  logic [1:0]         s1_mode_reg;
  logic [WIDTH-1:0]   s1_data_reg;

  logic               out_valid_reg;
  logic [WIDTH-1:0]   out_data_reg;
  logic               out_carry_reg;
  logic               out_zero_reg;

  logic [MAG_W-1:0]   shift_ext;
  logic [MAG_W-1:0]   mag_next;
  logic [MAG_W-1:0]   rot_mag;
  logic [MAG_W-1:0]   rot_comp;
  logic [WIDTH-1:0]   result_next;
  logic               carry_next;

  assign adv2     = !out_valid_reg || out_ready;
  assign adv1     = !s1_valid_reg || adv2;
  assign in_ready = adv1;

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_carry = out_carry_reg;
  assign out_zero  = out_zero_reg;

  always_comb begin
    shift_ext = {in_shift[SHIFT_W-1], in_shift};
    mag_next  = in_shift[SHIFT_W-1] ? (~shift_ext + 1'b1) : shift_ext;
  end

  always_comb begin
    rot_mag     = (s1_mag_reg == MAG_FULL) ? '0 : s1_mag_reg;
    rot_comp    = MAG_FULL - rot_mag;
    result_next = s1_data_reg;
    carry_next  = 1'b0;
    case (s1_mode_reg)
      2'b10: begin
        if (s1_left_reg)
          result_next = (s1_data_reg << rot_mag) | (s1_data_reg >> rot_comp);
        else
          result_next = (s1_data_reg >> rot_mag) | (s1_data_reg << rot_comp);
        if (rot_mag != '0)
          carry_next = s1_left_reg ? result_next[0] : result_next[WIDTH-1];
      end
      default: begin
        if (s1_left_reg)
          result_next = s1_data_reg << s1_mag_reg;
        else if (s1_mode_reg == 2'b01)
          result_next = $signed(s1_data_reg) >>> s1_mag_reg;
        else
          result_next = s1_data_reg >> s1_mag_reg;
        // The last bit to leave is data[WIDTH-m] going left, data[m-1] going right.
        if (s1_mag_reg != '0)
          carry_next = s1_left_reg ? s1_data_reg[IDX_W'(MAG_FULL - s1_mag_reg)]
                                   : s1_data_reg[IDX_W'(s1_mag_reg - 1'b1)];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_carry_reg <= 1'b0;
      out_zero_reg  <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_left_reg <= !in_shift[SHIFT_W-1] && (in_shift != '0);
          s1_mag_reg  <= mag_next;
          s1_mode_reg <= in_mode;
          s1_data_reg <= in_data;
        end
      end
      // Output registers only load on a real result, so they hold while stalled.
      if (adv2) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_data_reg  <= result_next;
          out_carry_reg <= carry_next;
          out_zero_reg  <= (result_next == '0);
        end
      end
    end
  end

endmodule
